// File: rtl/imem_stream_loader_pkg.sv
// Shared types for the instruction-memory stream loader: FSM state encoding
// and word-packing constants.
package imem_stream_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_stream_loader_byte_packer.sv
// Packs stream bytes MSB-first into a 32-bit word; byte 0 lands in [31:24].
// Unfilled low bytes stay zero because the buffer is cleared between words.
module byte_packer
    import imem_stream_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic [7:0]       data_i,
    input  logic             last_i,
    output logic [31:0]      word_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    logic [31:0]      word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (clr_i) begin
            word_d = '0;
            cnt_d  = '0;
            last_d = 1'b0;
        end else if (shift_i) begin
            // The byte counter selects the lane, so a short final word keeps zeros below.
            case (cnt_q)
                2'd0:    word_d[31:24] = data_i;
                2'd1:    word_d[23:16] = data_i;
                2'd2:    word_d[15:8]  = data_i;
                default: word_d[7:0]   = data_i;
            endcase
            cnt_d  = cnt_q + CNT_W'(1);
            last_d = last_q | last_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign word_o = word_q;
    assign cnt_o  = cnt_q;
    assign last_o = last_q;

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: packs a byte stream into big-endian words, writes them to
// instruction memory, then enables the CPU until halted.
module imem_stream_loader
    import imem_stream_loader_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    input  logic              halt,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    output logic              cpu_enable,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded,
    output loader_state_t     dbg_state_o
);

    // Stream handshake: a byte transfers on a rising edge where s_valid and
    // s_ready are both high; s_ready is a pure decode of state (high in LOAD only).
    localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [31:0]       addr_hold_q, addr_hold_d;
    logic [DATA_W-1:0] data_hold_q, data_hold_d;

    logic              pk_clr, pk_shift, pk_last;
    logic [31:0]       pk_word;
    logic [CNT_W-1:0]  pk_cnt;
    logic              byte_ends_word;
    logic [31:0]       wr_addr;

    byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (pk_clr),
        .shift_i (pk_shift),
        .data_i  (s_data),
        .last_i  (s_last),
        .word_o  (pk_word),
        .cnt_o   (pk_cnt),
        .last_o  (pk_last)
    );

    assign wr_addr        = 32'({word_idx_q, 2'b00});
    assign byte_ends_word = s_last || (pk_cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        words_d     = words_q;
        addr_hold_d = addr_hold_q;
        data_hold_d = data_hold_q;
        pk_clr      = 1'b0;
        pk_shift    = 1'b0;
        case (state_q)
            IDLE, ERR: begin
                if (load_start) begin
                    pk_clr     = 1'b1;
                    word_idx_d = '0;
                    words_d    = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                pk_shift = s_valid;
                if (s_valid && byte_ends_word) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                pk_clr      = 1'b1;
                word_idx_d  = word_idx_q + 1'b1;
                words_d     = (words_q == WORDS_MAX) ? words_q : words_q + 1'b1;
                addr_hold_d = wr_addr;
                data_hold_d = pk_word;
                // A final word that exactly fills memory still counts as a good image.
                if (pk_last) begin
                    state_d = RUN;
                end else if (&word_idx_q) begin
                    state_d = ERR;
                end else begin
                    state_d = LOAD;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_idx_q  <= '0;
            words_q     <= '0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            words_q     <= words_d;
            addr_hold_q <= addr_hold_d;
            data_hold_q <= data_hold_d;
        end
    end

    // Address/data show the live word during WRITE and the last written word otherwise.
    assign wen_ext      = (state_q == WRITE);
    assign ren_ext      = 1'b0;
    assign addr_ext     = wen_ext ? wr_addr : addr_hold_q;
    assign wdata_ext    = wen_ext ? pk_word : data_hold_q;
    assign s_ready      = (state_q == LOAD);
    assign cpu_enable   = (state_q == RUN);
    assign done         = (state_q == RUN);
    assign error        = (state_q == ERR);
    assign words_loaded = words_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader with a 4-word memory so overflow is reachable.
module tb_imem_stream_loader;
    import imem_stream_loader_pkg::*;

    localparam int AW      = 2;
    localparam int CAP     = 1 << AW;
    localparam int TIMEOUT = 20;

    logic          clk = 1'b0;
    logic          rst, load_start, s_valid, s_ready, s_last, halt;
    logic [7:0]    s_data;
    logic [31:0]   addr_ext, wdata_ext;
    logic          wen_ext, ren_ext, cpu_enable, done, error;
    logic [AW:0]   words_loaded;
    loader_state_t dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int writes_seen = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  img[$];

    always #5 clk = ~clk;

    imem_stream_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .halt         (halt),
        .addr_ext     (addr_ext),
        .wen_ext      (wen_ext),
        .ren_ext      (ren_ext),
        .wdata_ext    (wdata_ext),
        .cpu_enable   (cpu_enable),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded),
        .dbg_state_o  (dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected memory writes for the first n bytes of img: whole words, plus a
    // zero-filled tail word when the image ends there, capped at memory capacity.
    task automatic expect_image(input int n, input bit last);
        int words;
        logic [31:0] data;
        words = last ? (n + 3) / 4 : n / 4;
        if (words > CAP) words = CAP;
        for (int w = 0; w < words; w++) begin
            data = 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < n) data = data | (32'(img[4 * w + b]) << (24 - 8 * b));
            end
            exp_q.push_back({32'(4 * w), data});
        end
    endtask

    task automatic monitor();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst && wen_ext) begin
                writes_seen++;
                check("wr_s_ready_low", 64'(s_ready), 64'(0));
                check("wr_ren_low", 64'(ren_ext), 64'(0));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             addr_ext, wdata_ext);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr_data", {addr_ext, wdata_ext}, e);
                end
            end
        end
    endtask

    // Called and returns at a falling edge; the byte transfers on the rising
    // edge following a falling edge where s_ready is seen high.
    task automatic send_byte(input logic [7:0] d, input bit last, output bit ok);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        ok      = 1'b0;
        for (int c = 0; c < TIMEOUT; c++) begin
            if (s_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_image(input int n, input bit last, input int gap_max, output int accepted);
        bit ok;
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
            end
            send_byte(img[i], last && (i == n - 1), ok);
            if (!ok) break;
            accepted++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic pulse_halt();
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, 64'({s_ready, wen_ext, ren_ext, cpu_enable, done, error}), 64'(0));
        check({tag, "_addr"}, 64'(addr_ext), 64'(0));
        check({tag, "_wdata"}, 64'(wdata_ext), 64'(0));
        check({tag, "_words"}, 64'(words_loaded), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int w0;
        bit ok;

        rst = 1'b1; load_start = 1'b0; s_valid = 1'b0; s_data = 8'h0;
        s_last = 1'b0; halt = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Full-word load: two words, enable one cycle after the second write
        img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        expect_image(8, 1'b1);
        pulse_start();
        send_image(8, 1'b1, 0, acc);
        check("full_accepted", 64'(acc), 64'(8));
        check("full_wen_final", 64'(wen_ext), 64'(1));
        check("full_wr2", {addr_ext, wdata_ext}, {32'h4, 32'h9ABCDEF0});
        check("full_en_during_write", 64'(cpu_enable), 64'(0));
        @(negedge clk);
        check("full_run", 64'({cpu_enable, done, error}), 64'(3'b110));
        check("full_words", 64'(words_loaded), 64'(2));
        check("full_hold", {addr_ext, wdata_ext}, {32'h4, 32'h9ABCDEF0});
        check("full_exp_drained", 64'(exp_q.size()), 64'(0));

        // load_start is ignored in RUN; halt drops the enable next cycle
        pulse_start();
        check("run_ignores_start", 64'({cpu_enable, s_ready}), 64'(2'b10));
        check("run_words_kept", 64'(words_loaded), 64'(2));
        pulse_halt();
        check("halt_en_low", 64'({cpu_enable, done}), 64'(0));
        @(negedge clk);
        check("idle_ready_low", 64'(s_ready), 64'(0));

        // Partial last word, reloading from address 0
        img = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        expect_image(5, 1'b1);
        pulse_start();
        send_image(5, 1'b1, 0, acc);
        check("part_accepted", 64'(acc), 64'(5));
        check("part_wr2", {addr_ext, wdata_ext}, {32'h4, 32'h15000000});
        @(negedge clk);
        check("part_run", 64'(cpu_enable), 64'(1));
        check("part_words", 64'(words_loaded), 64'(2));
        pulse_halt();

        // Back-pressure: random gaps, s_valid held through WRITE when gap is 0
        img = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
        expect_image(10, 1'b1);
        w0 = writes_seen;
        pulse_start();
        send_image(10, 1'b1, 3, acc);
        check("bp_accepted", 64'(acc), 64'(10));
        @(negedge clk);
        check("bp_run", 64'(cpu_enable), 64'(1));
        check("bp_words", 64'(words_loaded), 64'(3));
        check("bp_write_count", 64'(writes_seen - w0), 64'(3));
        pulse_halt();

        // Overflow: 16 bytes fill all 4 words, the 17th is never accepted
        img = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
        expect_image(16, 1'b0);
        w0 = writes_seen;
        pulse_start();
        send_image(16, 1'b0, 1, acc);
        check("ovf_accepted", 64'(acc), 64'(16));
        check("ovf_wr4", {addr_ext, wdata_ext}, {32'hC, 32'h0C0D0E0F});
        send_byte(8'h10, 1'b0, ok);
        s_valid = 1'b0;
        check("ovf_17th_refused", 64'(ok), 64'(0));
        check("ovf_flags", 64'({error, s_ready, cpu_enable, done}), 64'(4'b1000));
        check("ovf_words", 64'(words_loaded), 64'(4));
        check("ovf_write_count", 64'(writes_seen - w0), 64'(4));
        check("ovf_exp_drained", 64'(exp_q.size()), 64'(0));

        // Restart from ERR; s_last on a 4th byte gives one write, no padding word
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        expect_image(4, 1'b1);
        w0 = writes_seen;
        pulse_start();
        check("err_cleared", 64'({error, s_ready}), 64'(2'b01));
        send_image(4, 1'b1, 0, acc);
        check("err_restart_wr", {addr_ext, wdata_ext}, {32'h0, 32'hDEADBEEF});
        @(negedge clk);
        @(negedge clk);
        check("exact_run", 64'({cpu_enable, error}), 64'(2'b10));
        check("exact_words", 64'(words_loaded), 64'(1));
        check("exact_write_count", 64'(writes_seen - w0), 64'(1));
        pulse_halt();

        // Reset after 2 bytes of word 1: partial word discarded
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        expect_image(6, 1'b0);
        pulse_start();
        send_image(6, 1'b0, 0, acc);
        check("rst_mid_accepted", 64'(acc), 64'(6));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_exp_drained", 64'(exp_q.size()), 64'(0));
        check_reset_outputs("rst_mid");
        img = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        expect_image(4, 1'b1);
        pulse_start();
        send_image(4, 1'b1, 0, acc);
        check("rst_fresh_wr", {addr_ext, wdata_ext}, {32'h0, 32'hC1C2C3C4});
        @(negedge clk);
        check("rst_fresh_run", 64'(cpu_enable), 64'(1));
        pulse_halt();
        check("final_exp_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_stream_loader.md
# imem_stream_loader

Boot-time loader placed directly upstream of the pipelined CPU. It accepts a byte stream over a valid/ready handshake and packs the bytes into 32-bit big-endian words. It writes each word into instruction memory through the CPU's external instruction-memory port (`addr_ext`/`wen_ext`/`ren_ext`/`wdata_ext`). When the image is complete it raises the CPU `enable` and holds it until halted.

## Interface
Parameters:
- `ADDR_W`, 9, instruction-memory word-address width; capacity is 2^ADDR_W words.
- `DATA_W`, 32, memory word width; fixed at 32, 4 bytes per word.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_start`  in  1  single-cycle pulse that starts a load; honoured only in IDLE and ERR.
- `s_valid`  in  1  stream byte valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `s_data`  in  8  stream byte.
- `s_last`  in  1  marks the final byte of the image; qualified by `s_valid & s_ready`.
- `halt`  in  1  stops the CPU; honoured only in RUN.
- `addr_ext`  out  32  byte address to instruction memory, equal to word_idx<<2.
- `wen_ext`  out  1  instruction-memory write strobe.
- `ren_ext`  out  1  tied 0.
- `wdata_ext`  out  32  packed word.
- `cpu_enable`  out  1  drives the CPU `enable` input.
- `done`  out  1  high in RUN.
- `error`  out  1  high in ERR: image exceeds capacity.
- `words_loaded`  out  ADDR_W+1  count of words written in the current load.

## Operation
- States: IDLE, LOAD, WRITE, RUN, ERR.
- **IDLE:**
  - `s_ready`=0.
  - On `load_start`, clear byte_cnt, word_idx, `words_loaded` and the packing buffer, then go to LOAD.
- **LOAD:**
  - `s_ready`=1.
  - Each accepted byte shifts into the buffer MSB-first, so byte 0 lands in [31:24], and byte_cnt increments.
  - After the 4th accepted byte, go to WRITE.
  - If `s_last` arrives on byte k<4, the unfilled low bytes are zero, the last flag is set, and the state goes to WRITE.
- **WRITE:** exactly one cycle.
  - Outputs: `wen_ext`=1, `addr_ext`=word_idx<<2, `wdata_ext`=buffer, `s_ready`=0.
  - Then word_idx and `words_loaded` increment and byte_cnt clears.
  - Next state:
    - RUN if the last flag is set;
    - otherwise ERR if word_idx was 2^ADDR_W−1;
    - otherwise LOAD.
- **RUN:**
  - `cpu_enable`=1 and `done`=1.
  - On `halt`, go to IDLE; `cpu_enable` is 0 from the next cycle.
- **ERR:**
  - `error`=1, `s_ready`=0, and no writes are issued.
  - `load_start` restarts the load exactly as from IDLE.
- Ignored inputs:
  - `load_start` in LOAD, WRITE and RUN.
  - `halt` outside RUN.
  - `s_valid` when `s_ready`=0.
- `s_last` on a 4th byte produces a single WRITE followed by RUN; no padding word is written.
- `wdata_ext` and `addr_ext` hold their last values outside WRITE; only `wen_ext` qualifies them.

## Timing
- Reset values:
  - state IDLE;
  - `s_ready`, `wen_ext`, `ren_ext`, `cpu_enable`, `done`, `error` all 0;
  - `addr_ext`, `wdata_ext`, `words_loaded` all 0.
- All outputs are registered or decoded from registered state only.
- `s_ready` does not depend combinationally on `s_valid`.
- WRITE occurs in the cycle after the 4th (or last) byte is accepted.
- Peak throughput is 4 bytes per 5 cycles.
- `cpu_enable` rises in the cycle after the final WRITE.
- `rst` in any state, including mid-LOAD or mid-WRITE, returns the loader to reset values on the next edge. A partial word is discarded. A `wen_ext` pulse already asserted in that cycle still completes.
- `words_loaded` saturates at 2^ADDR_W.

## Structure
- The shared CPU package holds:
  - the state enum `loader_state_t` (IDLE, LOAD, WRITE, RUN, ERR);
  - the constant `BYTES_PER_WORD` = 4.
- Sub-module `byte_packer`: 4-byte MSB-first shift buffer, 2-bit byte counter, last flag, and synchronous clear. The FSM, address counter and memory-port drive live in the top.

## Test plan
- **Full-word load:** `load_start`, then bytes 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0xF0 with `s_last` on the final byte. Required: two WRITE pulses, addr 0x0 with data 0x12345678, then addr 0x4 with data 0x9ABCDEF0. `cpu_enable`=1 one cycle after the second write, and `words_loaded`=2.
- **Partial last word:** 5 bytes 0x11..0x15 with `s_last` on 0x15. Required: second write is 0x15000000 at addr 0x4, then RUN.
- **Back-pressure and gaps:** random `s_valid` gaps, with `s_valid` held during WRITE. Required: no byte is lost or duplicated, and `s_ready`=0 during every WRITE cycle.
- **Overflow:** `ADDR_W`=2 and 17 bytes without an `s_last` within the first 16. Required: 4 writes, then `error`=1, `s_ready`=0, no 5th write, and `cpu_enable` stays 0.
- **Reset mid-load:** `rst` after 2 bytes of word 1. Required: all outputs at reset values, and a fresh load writes its first word to addr 0x0.
- **Halt and reload:** in RUN, a `load_start` pulse is ignored. `halt` gives `cpu_enable`=0 next cycle, and a following `load_start` reloads from addr 0.
